piso_shift_register: RTL and testbench

Parallel-in, serial-out shift register: the transmit end of the team's 4-bit serial-in shift register.
- Accepts a parallel word over a valid/ready handshake.
- Emits the word one bit per enabled cycle on a serial line, MSB first by default, with valid and last-bit markers.
- Feeding sr_o into the receiver's x_i for DATA_W enabled cycles reproduces the word on the receiver's parallel output.

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_shift_register.sv | 124 ++++++++++++
 tb/tb_piso_shift_register.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in, serial-out transmitter:
// the controller state encoding and the bit-counter width helper.
package piso_pkg;

   // Two-state controller: waiting for a word, or streaming one out.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   // Bit counter width for a given word width. The counter runs
   // DATA_W-1 down to 0, so $clog2(DATA_W) bits are enough. The floor of
   // one bit keeps the vector legal for degenerate widths.
   function automatic int cnt_width(input int data_w);
      return (data_w < 2) ? 1 : $clog2(data_w);
   endfunction

endpackage : piso_pkg

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register. A word is accepted over a
// valid/ready handshake and sent one bit per enabled cycle, MSB first by
// default. The word boundary is marked with last_o. A new word may be
// accepted on the same edge that consumes the final bit, so words stream
// back to back with no idle cycle between them.
module piso_shift_register
   import piso_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic              load_ready_o,
   input  logic              tx_en_i,
   output logic              sr_o,
   output logic              sr_valid_o,
   output logic              last_o
);

   localparam int              CNT_W   = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);
   // Bit position that faces the serial line.
   localparam int              OUT_IDX = MSB_FIRST ? DATA_W - 1 : 0;

   piso_state_t       state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic at_last;    // the bit on the line is the final bit of the word
   logic consume;    // the bit on the line is taken on this edge
   logic load_hs;    // a new word is captured on this edge
   logic [DATA_W-1:0] shifted;

   assign at_last = (state_q == SHIFT) && (cnt_q == '0);
   assign consume = (state_q == SHIFT) && tx_en_i;

   // Ready is combinational from tx_en_i on purpose: when the final bit is
   // being consumed the slot frees up in the same cycle, which is what lets
   // the next word follow without a gap.
   always_comb begin
      load_ready_o = (state_q == IDLE) || (at_last && tx_en_i);
   end

   assign load_hs = load_valid_i && load_ready_o;

   // One-position move toward the output end, zero-filled behind the word.
   generate
      if (MSB_FIRST) begin : g_shift_msb
         assign shifted = {shreg_q[DATA_W-2:0], 1'b0};
      end else begin : g_shift_lsb
         assign shifted = {1'b0, shreg_q[DATA_W-1:1]};
      end
   endgenerate

   // State register with asynchronous clear; an abandoned word never resumes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: leave SHIFT only after the final bit is consumed
   // with no replacement word waiting.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (load_hs) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (at_last && tx_en_i && !load_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: capture on handshake, otherwise advance one bit
   // per enabled cycle, otherwise hold (stall).
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_hs) begin
         shreg_d = load_data_i;
         cnt_d   = CNT_TOP;
      end else if (consume && (cnt_q != '0)) begin
         shreg_d = shifted;
         cnt_d   = cnt_q - 1'b1;
      end
   end

   // Shift register and bit counter, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Serial outputs depend on registered state only, so they are glitch-free
   // with respect to the inputs and go quiet the moment reset asserts.
   always_comb begin
      sr_o       = 1'b0;
      sr_valid_o = 1'b0;
      last_o     = 1'b0;
      if (state_q == SHIFT) begin
         sr_o       = shreg_q[OUT_IDX];
         sr_valid_o = 1'b1;
         last_o     = (cnt_q == '0);
      end
   end

endmodule : piso_shift_register

// File: tb/tb_piso_shift_register.sv
module tb_piso_shift_register;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         lv = 1'b0;
   logic [W-1:0] d = '0;
   logic         en = 1'b0;

   logic rdy_m, sr_m, v_m, l_m;
   logic rdy_l, sr_l, v_l, l_l;

   always #5 clk = ~clk;

   piso_shift_register #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset),
      .load_valid_i(lv), .load_data_i(d), .load_ready_o(rdy_m),
      .tx_en_i(en), .sr_o(sr_m), .sr_valid_o(v_m), .last_o(l_m)
   );

   piso_shift_register #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset),
      .load_valid_i(lv), .load_data_i(d), .load_ready_o(rdy_l),
      .tx_en_i(en), .sr_o(sr_l), .sr_valid_o(v_l), .last_o(l_l)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a word in flight and how many of its bits are gone.
   bit           m_busy = 1'b0;
   int           m_idx  = 0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] rx     = '0;   // receiver model fed from dut_m's serial line
   logic         exp_rdy;

   typedef struct {
      logic         lv;
      logic [W-1:0] d;
      logic         en;
      logic         rdy;
      logic         srm;
      logic         srl;
      logic         v;
      logic         last;
   } vec_t;

   vec_t tbl[24];

   function automatic logic word_bit(input logic [W-1:0] w, input int idx, input bit msb);
      return msb ? w[W-1-idx] : w[idx];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic e_sr_m, e_sr_l, e_last;
      exp_rdy = !m_busy || ((m_idx == W-1) && en);
      e_sr_m  = m_busy ? word_bit(m_word, m_idx, 1'b1) : 1'b0;
      e_sr_l  = m_busy ? word_bit(m_word, m_idx, 1'b0) : 1'b0;
      e_last  = m_busy && (m_idx == W-1);
      chk({tag, " ready_m"}, {31'd0, rdy_m}, {31'd0, exp_rdy});
      chk({tag, " ready_l"}, {31'd0, rdy_l}, {31'd0, exp_rdy});
      chk({tag, " sr_m"},    {31'd0, sr_m},  {31'd0, e_sr_m});
      chk({tag, " sr_l"},    {31'd0, sr_l},  {31'd0, e_sr_l});
      chk({tag, " valid_m"}, {31'd0, v_m},   {31'd0, m_busy});
      chk({tag, " valid_l"}, {31'd0, v_l},   {31'd0, m_busy});
      chk({tag, " last_m"},  {31'd0, l_m},   {31'd0, e_last});
      chk({tag, " last_l"},  {31'd0, l_l},   {31'd0, e_last});
   endtask

   // Drive inputs early in the cycle and compare settled outputs.
   task automatic drive(input logic lv_i, input logic [W-1:0] d_i, input logic en_i, input string tag);
      lv = lv_i; d = d_i; en = en_i;
      #2;
      check_model(tag);
   endtask

   // Take the clock edge and advance the model.
   task automatic advance();
      logic hs, take, line_bit;
      hs       = lv && exp_rdy;
      take     = m_busy && en;
      line_bit = sr_m;
      @(posedge clk);
      if (take) begin
         rx = {rx[W-2:0], line_bit};
         if (m_idx == W-1) begin
            m_busy = 1'b0;
            chk("loopback rx", {28'd0, rx}, {28'd0, m_word});
         end else begin
            m_idx++;
         end
      end
      if (hs) begin
         m_busy = 1'b1;
         m_word = d;
         m_idx  = 0;
      end
      #1;
   endtask

   task automatic step(input logic lv_i, input logic [W-1:0] d_i, input logic en_i, input string tag);
      drive(lv_i, d_i, en_i, tag);
      advance();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " ready_m"}, {31'd0, rdy_m}, 32'd1);
      chk({tag, " ready_l"}, {31'd0, rdy_l}, 32'd1);
      chk({tag, " outs_m"},  {29'd0, sr_m, v_m, l_m}, 32'd0);
      chk({tag, " outs_l"},  {29'd0, sr_l, v_l, l_l}, 32'd0);
   endtask

   // Assert reset mid-cycle with a load offered; it must be ignored.
   task automatic apply_reset(input string tag);
      reset = 1'b1; lv = 1'b1; d = W'($urandom); en = 1'b1;
      #1;
      check_reset_outputs({tag, " immediate"});
      m_busy = 1'b0; m_idx = 0; rx = '0;
      @(posedge clk);
      #1;
      check_reset_outputs({tag, " held"});
      reset = 1'b0; lv = 1'b0;
   endtask

   initial begin
      logic [W-1:0] seq;

      // Single word, back-to-back words, and stall, as explicit vectors.
      tbl[0]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[20] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[21] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[22] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[23] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      // Power-up reset, then ten idle cycles with nothing offered.
      #1;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, "idle");
      apply_reset("idle reset");
      step(1'b0, '0, 1'b1, "after idle reset");

      // Vector table.
      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].lv, tbl[i].d, tbl[i].en, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl ready", i), {31'd0, rdy_m}, {31'd0, tbl[i].rdy});
         chk($sformatf("vec%0d tbl sr_m", i),  {31'd0, sr_m},  {31'd0, tbl[i].srm});
         chk($sformatf("vec%0d tbl sr_l", i),  {31'd0, sr_l},  {31'd0, tbl[i].srl});
         chk($sformatf("vec%0d tbl valid", i), {31'd0, v_m},   {31'd0, tbl[i].v});
         chk($sformatf("vec%0d tbl last", i),  {31'd0, l_m},   {31'd0, tbl[i].last});
         advance();
         $display("[TB] vec%0d lv=%0b d=%h en=%0b -> rdy=%0b sr_m=%0b sr_l=%0b v=%0b last=%0b",
                  i, tbl[i].lv, tbl[i].d, tbl[i].en, tbl[i].rdy, tbl[i].srm, tbl[i].srl, tbl[i].v, tbl[i].last);
      end

      // Reset two bits into 4'hF, then 4'h6 must go out cleanly.
      step(1'b1, 4'hF, 1'b1, "F load");
      step(1'b0, '0, 1'b1, "F bit0");
      step(1'b0, '0, 1'b1, "F bit1");
      apply_reset("midword reset");
      step(1'b1, 4'h6, 1'b1, "6 load");
      seq = '0;
      for (int i = 0; i < W; i++) begin
         drive(1'b0, '0, 1'b1, "6 bits");
         seq = {seq[W-2:0], sr_m};
         advance();
      end
      chk("after reset word", {28'd0, seq}, 32'h6);
      $display("[TB] post-reset word sent as %b", seq);
      step(1'b0, '0, 1'b1, "6 idle");

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0), "rand");
      end
      // Drain whatever word is in flight.
      for (int i = 0; i < W + 1; i++) step(1'b0, '0, 1'b1, "drain");
      chk("drained idle", {31'd0, v_m}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_piso_shift_register
